master_reader: RTL and testbench

MASTER_READER -- requirements
Module: master_reader

---
 rtl/master_reader_pkg.sv | 27 ++
 rtl/rd_fifo.sv | 59 +++++
 rtl/master_reader.sv | 165 ++++++++++++++++
 tb/tb_master_reader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/master_reader_pkg.sv
// Shared definitions for the burst read master: FSM state encoding,
// parameter bounds and the burst-length decode helper.
package master_reader_pkg;

    // Controller states, encoded so that IDLE is all-zero out of reset.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Legal ranges for the top-level parameters.
    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;
    localparam int FIFO_DEPTH_MIN = 4;
    localparam int FIFO_DEPTH_MAX = 16;

    // Width of a read counter able to hold 1..256.
    localparam int BURST_W = 9;

    // A programmed length of zero stands for a full 256-read burst.
    function automatic logic [BURST_W-1:0] burst_count(input logic [7:0] len);
        return (len == 8'd0) ? BURST_W'(256) : BURST_W'(len);
    endfunction

endpackage

// File: rtl/rd_fifo.sv
// Synchronous capture FIFO: single clock, synchronous active-low reset,
// first-word fall-through head, occupancy count and full/empty flags.
module rd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping; push and pop together keep the count.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write port.
    // NOTE: the array is deliberately not reset; only the pointers and count
    // are, and the head is masked while empty, so stale contents never leak.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/master_reader.sv
// Burst read master: issues up to 256 single-cycle read strobes to a
// fixed-latency slave, captures the returned bytes into a FIFO in issue
// order and presents them on a valid/ready output.
// Optional feature: define MASTER_READER_CSUM_EN to add an 8-bit XOR
// checksum output over the bytes captured in the current burst.
module master_reader
    import master_reader_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic [7:0]  burst_len,
    output logic        ram_rd_rq,
    output logic [15:0] rd_addr,
    input  logic [7:0]  data_i,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
`ifdef MASTER_READER_CSUM_EN
    ,
    output logic [7:0]  csum
`endif
);

    // Out-of-range parameters are clamped into the supported window.
    localparam int LAT = (RD_LATENCY < RD_LATENCY_MIN) ? RD_LATENCY_MIN :
                         (RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX : RD_LATENCY;
    localparam int DEPTH = (FIFO_DEPTH < FIFO_DEPTH_MIN) ? FIFO_DEPTH_MIN :
                           (FIFO_DEPTH > FIFO_DEPTH_MAX) ? FIFO_DEPTH_MAX : FIFO_DEPTH;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t               state;
    state_t               state_nxt;
    logic [15:0]          base_q;
    logic [BURST_W-1:0]   len_q;
    logic [BURST_W-1:0]   issued_q;
    logic [LAT-1:0]       vpipe;
    logic [CNT_W-1:0]     inflight_q;
    logic [CNT_W-1:0]     inflight_nxt;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W:0]       committed;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 start_ok;
    logic                 can_issue;
    logic                 issue_ok;
    logic                 last_issue;
    logic                 capture;

    assign start_ok   = (state == IDLE) && start;
    assign capture    = vpipe[LAT-1];

    // A slot is reserved for every read in flight, so the FIFO can never be
    // asked to accept more data than it has room for.
    assign committed  = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign can_issue  = !fifo_full && (committed < (CNT_W+1)'(DEPTH));
    assign issue_ok   = (state == ISSUE) && can_issue;
    assign last_issue = (issued_q == len_q - 1'b1);

    assign ram_rd_rq  = issue_ok;
    assign rd_addr    = issue_ok ? (base_q + 16'(issued_q)) : 16'h0000;
    assign out_valid  = !fifo_empty;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_l) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and status decode.
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (issue_ok && last_issue) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (inflight_nxt == '0) state_nxt = FINISH;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Burst parameters and the running address offset.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            base_q   <= 16'h0000;
            len_q    <= '0;
            issued_q <= '0;
        end else if (start_ok) begin
            base_q   <= base_addr;
            len_q    <= burst_count(burst_len);
            issued_q <= '0;
        end else if (issue_ok) begin
            issued_q <= issued_q + 1'b1;
        end
    end

    // Read-latency valid pipe: the tap at the far end marks data_i as valid.
    always_ff @(posedge clk) begin
        if (!rst_l) vpipe <= '0;
        else        vpipe <= (vpipe << 1) | LAT'(issue_ok);
    end

    // Next in-flight count: a strobe and a capture in the same cycle cancel.
    always_comb begin
        inflight_nxt = inflight_q;
        if (issue_ok && !capture)      inflight_nxt = inflight_q + 1'b1;
        else if (!issue_ok && capture) inflight_nxt = inflight_q - 1'b1;
    end

    // In-flight read counter.
    always_ff @(posedge clk) begin
        if (!rst_l) inflight_q <= '0;
        else        inflight_q <= inflight_nxt;
    end

    rd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst_l     (rst_l),
        .push      (capture),
        .push_data (data_i),
        .pop       (out_ready),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef MASTER_READER_CSUM_EN
    logic [7:0] csum_q;

    // Running XOR of captured bytes; cleared when a burst is accepted and
    // left untouched after the last capture so it holds through done.
    always_ff @(posedge clk) begin
        if (!rst_l)        csum_q <= 8'h00;
        else if (start_ok) csum_q <= 8'h00;
        else if (capture)  csum_q <= csum_q ^ data_i;
    end

    assign csum = csum_q;
`endif

endmodule

// File: tb/tb_master_reader.sv
// Self-checking bench for master_reader. Two instances with different
// latency/depth share the burst controls; each has its own slave model that
// returns a table byte for the strobed address after the instance's latency.
// Expected addresses, bytes, counts and timing come from the burst rules.
module tb_master_reader;

    localparam int LAT_A   = 1;
    localparam int DEPTH_A = 4;
    localparam int LAT_B   = 3;
    localparam int DEPTH_B = 8;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        start;
    logic [15:0] base_addr;
    logic [7:0]  burst_len;
    logic        out_ready;

    logic        rq    [2];
    logic [15:0] addr  [2];
    logic [7:0]  din   [2];
    logic [7:0]  dout  [2];
    logic        ov    [2];
    logic        busy  [2];
    logic        done  [2];
`ifdef MASTER_READER_CSUM_EN
    logic [7:0]  csum  [2];
    logic [7:0]  exp_csum;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          rdy_mode;   // 0: hold low, 1: hold high, 2: random
    logic [15:0] exp_base;
    int          exp_n;
    logic [7:0]  data_tab [256];
    int          issued    [2];
    int          popped    [2];
    int          done_cnt  [2];
    int          first_cyc [2];
    int          last_cyc  [2];
    int          done_cyc  [2];
    logic        pv [2][5];
    logic [15:0] pa [2][5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    master_reader #(.RD_LATENCY(LAT_A), .FIFO_DEPTH(DEPTH_A)) dut_a (
        .clk(clk), .rst_l(rst_l), .start(start), .base_addr(base_addr),
        .burst_len(burst_len), .ram_rd_rq(rq[0]), .rd_addr(addr[0]),
        .data_i(din[0]), .out_data(dout[0]), .out_valid(ov[0]),
        .out_ready(out_ready), .busy(busy[0]), .done(done[0])
`ifdef MASTER_READER_CSUM_EN
        , .csum(csum[0])
`endif
    );

    master_reader #(.RD_LATENCY(LAT_B), .FIFO_DEPTH(DEPTH_B)) dut_b (
        .clk(clk), .rst_l(rst_l), .start(start), .base_addr(base_addr),
        .burst_len(burst_len), .ram_rd_rq(rq[1]), .rd_addr(addr[1]),
        .data_i(din[1]), .out_data(dout[1]), .out_valid(ov[1]),
        .out_ready(out_ready), .busy(busy[1]), .done(done[1])
`ifdef MASTER_READER_CSUM_EN
        , .csum(csum[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? DEPTH_A : DEPTH_B;
    endfunction

    // Per cycle: pick out_ready, observe both DUTs, run the slave models.
    always @(negedge clk) begin
        int lat;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        for (int k = 0; k < 2; k++) begin
            if (rst_l) begin
                if (rq[k]) begin
                    if (issued[k] < exp_n) begin
                        check($sformatf("rd_addr%0d", k), addr[k], 16'(exp_base + issued[k]));
                        if (issued[k] == 0) first_cyc[k] = cyc;
                        last_cyc[k] = cyc;
                        issued[k]++;
                    end else begin
                        check($sformatf("extra_rq%0d", k), rq[k], 0);
                    end
                end
                if (ov[k] && out_ready) begin
                    if (popped[k] < exp_n) begin
                        check($sformatf("out_data%0d", k), dout[k], data_tab[8'(exp_base + popped[k])]);
                        popped[k]++;
                    end else begin
                        check($sformatf("extra_pop%0d", k), ov[k], 0);
                    end
                end
                if (done[k]) begin
                    done_cnt[k]++;
                    done_cyc[k] = cyc;
                    check($sformatf("done_all_issued%0d", k), issued[k], exp_n);
                    check($sformatf("done_single%0d", k), done_cnt[k], 1);
`ifdef MASTER_READER_CSUM_EN
                    check($sformatf("csum_at_done%0d", k), csum[k], exp_csum);
`endif
                end
            end
            lat = lat_of(k);
            for (int j = 4; j > 0; j--) begin
                pv[k][j] = pv[k][j-1];
                pa[k][j] = pa[k][j-1];
            end
            pv[k][0] = (rq[k] === 1'b1);
            pa[k][0] = addr[k];
            din[k] = pv[k][lat] ? data_tab[pa[k][lat][7:0]] : 8'($urandom);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++) begin
            issued[k] = 0; popped[k] = 0; done_cnt[k] = 0;
            first_cyc[k] = -1; last_cyc[k] = -1; done_cyc[k] = -1;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) data_tab[i] = 8'($urandom);
    endtask

    task automatic start_burst(input logic [15:0] b, input logic [7:0] l, output int sc);
        exp_base = b;
        exp_n    = (l == 8'd0) ? 256 : int'(l);
        clear_counts();
`ifdef MASTER_READER_CSUM_EN
        exp_csum = 8'h00;
        for (int i = 0; i < exp_n; i++) exp_csum ^= data_tab[8'(b + i)];
`endif
        base_addr = b;
        burst_len = l;
        sc        = cyc;
        start     = 1'b1;
        step();
        start     = 1'b0;
        base_addr = 16'($urandom);
        burst_len = 8'($urandom);
    endtask

    task automatic wait_complete(input string tag, input int budget);
        int t = 0;
        while (t < budget && !(done_cnt[0] >= 1 && done_cnt[1] >= 1 &&
                               !busy[0] && !busy[1] && !ov[0] && !ov[1])) begin
            step();
            t++;
        end
        check({tag, "_idle_drained"}, {busy[0], busy[1], ov[0], ov[1]}, 4'b0000);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_issued%0d", tag, k), issued[k], exp_n);
            check($sformatf("%s_popped%0d", tag, k), popped[k], exp_n);
            check($sformatf("%s_done_pulses%0d", tag, k), done_cnt[k], 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_rq%0d", tag, k), rq[k], 0);
            check($sformatf("%s_addr%0d", tag, k), addr[k], 0);
            check($sformatf("%s_busy%0d", tag, k), busy[k], 0);
            check($sformatf("%s_done%0d", tag, k), done[k], 0);
            check($sformatf("%s_valid%0d", tag, k), ov[k], 0);
            check($sformatf("%s_data%0d", tag, k), dout[k], 0);
`ifdef MASTER_READER_CSUM_EN
            check($sformatf("%s_csum%0d", tag, k), csum[k], 0);
`endif
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int t;
        rst_l = 1'b0; start = 1'b0; base_addr = 16'h0; burst_len = 8'h0;
        rdy_mode = 1; exp_base = 16'h0; exp_n = 0;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 5; j++) begin pv[k][j] = 1'b0; pa[k][j] = 16'h0; end
        clear_counts();
        fill_random();
        repeat (3) step();
        check_reset_outputs("reset");
        rst_l = 1'b1;
        step();

        // Basic burst with a permanently ready sink: back-to-back strobes.
        rdy_mode = 1;
        fill_random();
        start_burst(16'h0010, 8'd4, sc);
        wait_complete("basic", 200);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("basic_first_rq%0d", k), first_cyc[k], sc + 1);
            check($sformatf("basic_last_rq%0d", k), last_cyc[k], sc + 4);
            check($sformatf("basic_done_cyc%0d", k), done_cyc[k], sc + 4 + lat_of(k) + 1);
        end

        // Backpressure: the sink is stalled, issue stops once the FIFO is committed.
        rdy_mode = 0;
        fill_random();
        start_burst(16'($urandom), 8'd10, sc);
        repeat (40) step();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("bp_stalled_issue%0d", k), issued[k],
                  (depth_of(k) < 10) ? depth_of(k) : 10);
            check($sformatf("bp_busy%0d", k), busy[k], 1);
            check($sformatf("bp_valid%0d", k), ov[k], 1);
        end
        rdy_mode = 2;
        wait_complete("bp", 600);

        // Address wrap at the top of the 16-bit space.
        fill_random();
        start_burst(16'hFFFE, 8'd3, sc);
        wait_complete("wrap", 200);

        // Zero length means 256 reads.
        fill_random();
        start_burst(16'($urandom), 8'd0, sc);
        wait_complete("len256", 3000);

        // Reset in the middle of issuing: no done, no late captures.
        rdy_mode = 1;
        fill_random();
        start_burst(16'h0200, 8'd8, sc);
        t = 0;
        while (issued[0] < 2 && t < 20) begin step(); t++; end
        check("rst_mid_strobes_seen", issued[0], 2);
        rst_l = 1'b0;
        exp_n = 0;
        clear_counts();
        step();
        check_reset_outputs("rst_mid");
        rst_l = 1'b1;
        repeat (10) step();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_mid_no_push%0d", k), ov[k], 0);
            check($sformatf("rst_mid_no_done%0d", k), done_cnt[k], 0);
            check($sformatf("rst_mid_no_rq%0d", k), issued[k], 0);
            check($sformatf("rst_mid_idle%0d", k), busy[k], 0);
        end

        // Known bytes for the checksum, plus a start pulse while busy.
        fill_random();
        data_tab[8'h40] = 8'h01;
        data_tab[8'h41] = 8'h02;
        data_tab[8'h42] = 8'h04;
        data_tab[8'h43] = 8'h08;
        start_burst(16'h0040, 8'd4, sc);
        base_addr = 16'h1234;
        burst_len = 8'd20;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_complete("start_busy", 200);
`ifdef MASTER_READER_CSUM_EN
        for (int k = 0; k < 2; k++)
            check($sformatf("csum_hold%0d", k), csum[k], 8'h0F);
`endif

        // Random bursts under a random sink.
        rdy_mode = 2;
        for (int r = 0; r < 6; r++) begin
            fill_random();
            start_burst(16'($urandom), 8'($urandom_range(1, 40)), sc);
            wait_complete($sformatf("rand%0d", r), 600);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
